// File: rtl/regfile_sb_score.sv
// Pending scoreboard: one bit per register plus a running count of set bits,
// used by decode to spot read-after-write hazards on multi-cycle ops.
module regfile_sb_score #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          busy1,
  output logic          busy2,
  output logic [AW:0]   pend_count
);

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [AW:0]      count_q, count_d;
  logic             inc, dec;

  always_comb begin
    pend_d = pend_q;
    // Set is applied last so a same-cycle issue supersedes the writeback.
    if (clr_en) pend_d[clr_addr] = 1'b0;
    if (set_en) pend_d[set_addr] = 1'b1;

    inc = set_en && !pend_q[set_addr];
    dec = clr_en && pend_q[clr_addr] && !(set_en && (set_addr == clr_addr));

    count_d = count_q;
    if (inc && !dec)      count_d = count_q + (AW+1)'(1);
    else if (dec && !inc) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  assign busy1      = pend_q[ra1];
  assign busy2      = pend_q[ra2];
  assign pend_count = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with optional hard-wired zero register,
// write-to-read bypass and a pending-write scoreboard.
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy1,
  output logic             busy2,
  input  logic             regwrite,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             issue,
  input  logic [AW-1:0]    issue_addr,
  output logic [AW:0]      pend_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             write_ok, issue_ok;
  logic             pend1, pend2;
  logic             zero1, zero2, fwd1, fwd2;

  // Accesses to the zero register are dropped before reaching any state.
  assign write_ok = regwrite && !reset && !((ZERO_REG != 0) && (wa == '0));
  assign issue_ok = issue && !reset && !((ZERO_REG != 0) && (issue_addr == '0));

  always_comb begin
    mem_d = mem_q;
    if (write_ok) mem_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  regfile_sb_score #(.DEPTH(DEPTH)) u_score (
    .clk        (clk),
    .reset      (reset),
    .set_en     (issue_ok),
    .set_addr   (issue_addr),
    .clr_en     (write_ok),
    .clr_addr   (wa),
    .ra1        (ra1),
    .ra2        (ra2),
    .busy1      (pend1),
    .busy2      (pend2),
    .pend_count (pend_count)
  );

  assign zero1 = (ZERO_REG != 0) && (ra1 == '0);
  assign zero2 = (ZERO_REG != 0) && (ra2 == '0);
  assign fwd1  = (BYPASS != 0) && write_ok && (wa == ra1);
  assign fwd2  = (BYPASS != 0) && write_ok && (wa == ra2);

  // A forwarded value is only busy again if a new op targets it this cycle.
  always_comb begin
    rd1   = zero1 ? '0 : (fwd1 ? wd : mem_q[ra1]);
    rd2   = zero2 ? '0 : (fwd2 ? wd : mem_q[ra2]);
    busy1 = zero1 ? 1'b0 : (fwd1 ? (issue_ok && (issue_addr == ra1)) : pend1);
    busy2 = zero2 ? 1'b0 : (fwd2 ? (issue_ok && (issue_addr == ra2)) : pend2);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb: one instance with zero
// register and bypass, one plain instance, both against a reference model.
module tb_regfile_sb;

  localparam int NI = 2;
  localparam int ZR [NI] = '{1, 0};
  localparam int BP [NI] = '{1, 0};

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ra1, ra2, wa, issue_addr;
  logic [15:0] wd;
  logic        regwrite, issue;

  logic [15:0] rd1_o [NI];
  logic [15:0] rd2_o [NI];
  logic        busy1_o [NI];
  logic        busy2_o [NI];
  logic [4:0]  cnt_o [NI];

  logic [15:0] m_mem [NI][16];
  bit          m_pend [NI][16];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_o[0]), .rd2(rd2_o[0]), .busy1(busy1_o[0]), .busy2(busy2_o[0]),
    .regwrite(regwrite), .wa(wa), .wd(wd), .issue(issue),
    .issue_addr(issue_addr), .pend_count(cnt_o[0])
  );

  regfile_sb #(.WIDTH(16), .DEPTH(16), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_o[1]), .rd2(rd2_o[1]), .busy1(busy1_o[1]), .busy2(busy2_o[1]),
    .regwrite(regwrite), .wa(wa), .wd(wd), .issue(issue),
    .issue_addr(issue_addr), .pend_count(cnt_o[1])
  );

  // Counter must always equal the number of pending registers.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      assert (int'(cnt_o[0]) == $countones(dut_a.u_score.pend_q))
        else $error("FAIL pop_inv_a cnt=%0d", cnt_o[0]);
      assert (int'(cnt_o[1]) == $countones(dut_b.u_score.pend_q))
        else $error("FAIL pop_inv_b cnt=%0d", cnt_o[1]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit w_ok(int k);
    return regwrite && !(ZR[k] != 0 && wa == 4'd0);
  endfunction

  function automatic bit i_ok(int k);
    return issue && !(ZR[k] != 0 && issue_addr == 4'd0);
  endfunction

  function automatic logic [15:0] exp_rd(int k, logic [3:0] ra);
    if (ZR[k] != 0 && ra == 4'd0) return 16'h0000;
    if (BP[k] != 0 && w_ok(k) && wa == ra) return wd;
    return m_mem[k][ra];
  endfunction

  function automatic logic exp_busy(int k, logic [3:0] ra);
    if (ZR[k] != 0 && ra == 4'd0) return 1'b0;
    if (BP[k] != 0 && w_ok(k) && wa == ra) return i_ok(k) && issue_addr == ra;
    return m_pend[k][ra];
  endfunction

  function automatic int exp_cnt(int k);
    int c = 0;
    for (int r = 0; r < 16; r++) c += int'(m_pend[k][r]);
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++)
      for (int r = 0; r < 16; r++) begin
        m_mem[k][r]  = 16'h0000;
        m_pend[k][r] = 1'b0;
      end
  endtask

  // Apply inputs mid-cycle, then compare every output against the model.
  task automatic drive(input logic r, input logic we, input logic [3:0] a,
                       input logic [15:0] d, input logic is, input logic [3:0] ia,
                       input logic [3:0] r1, input logic [3:0] r2);
    @(negedge clk);
    reset = r; regwrite = we; wa = a; wd = d;
    issue = is; issue_addr = ia; ra1 = r1; ra2 = r2;
    #1;
    if (!r) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("rd1[%0d]", k),   32'(rd1_o[k]),   32'(exp_rd(k, ra1)));
        check($sformatf("rd2[%0d]", k),   32'(rd2_o[k]),   32'(exp_rd(k, ra2)));
        check($sformatf("busy1[%0d]", k), 32'(busy1_o[k]), 32'(exp_busy(k, ra1)));
        check($sformatf("busy2[%0d]", k), 32'(busy2_o[k]), 32'(exp_busy(k, ra2)));
        check($sformatf("cnt[%0d]", k),   32'(cnt_o[k]),   32'(exp_cnt(k)));
      end
    end
  endtask

  task automatic commit();
    bit w [NI];
    bit i [NI];
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      w[k] = w_ok(k);
      i[k] = i_ok(k);
    end
    if (reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (w[k]) begin
          m_mem[k][wa]  = wd;
          m_pend[k][wa] = 1'b0;
        end
        if (i[k]) m_pend[k][issue_addr] = 1'b1;
      end
    end
    $display("cyc rst=%0b we=%0b wa=%0d wd=%h iss=%0b ia=%0d cnt_a=%0d cnt_b=%0d",
             reset, regwrite, wa, wd, issue, issue_addr, exp_cnt(0), exp_cnt(1));
  endtask

  task automatic idle_read(input logic [3:0] r1, input logic [3:0] r2);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, r1, r2);
  endtask

  initial begin
    model_reset();
    drive(1'b1, 1'b1, 4'd3, 16'hFFFF, 1'b1, 4'd3, 4'd0, 4'd0);
    commit();

    for (int a = 0; a < 16; a++) begin
      idle_read(4'(a), 4'(15 - a));
      check("rst_rd1", 32'(rd1_o[0]), 32'h0);
      check("rst_busy1", 32'(busy1_o[0]), 32'h0);
      check("rst_cnt", 32'(cnt_o[1]), 32'h0);
      commit();
    end

    drive(1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 4'd3, 4'd3);
    check("byp_rd1", 32'(rd1_o[0]), 32'hBEEF);
    check("nobyp_rd1", 32'(rd1_o[1]), 32'h0000);
    commit();
    idle_read(4'd3, 4'd3);
    check("wr_rd1_a", 32'(rd1_o[0]), 32'hBEEF);
    check("wr_rd1_b", 32'(rd1_o[1]), 32'hBEEF);
    commit();

    drive(1'b0, 1'b1, 4'd0, 16'h1234, 1'b1, 4'd0, 4'd0, 4'd0);
    commit();
    idle_read(4'd0, 4'd0);
    check("zero_rd1", 32'(rd1_o[0]), 32'h0);
    check("zero_busy1", 32'(busy1_o[0]), 32'h0);
    check("zero_cnt", 32'(cnt_o[0]), 32'h0);
    check("r0_rd1_b", 32'(rd1_o[1]), 32'h1234);
    commit();

    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 4'd0, 4'd5);
    commit();
    idle_read(4'd0, 4'd5);
    check("iss_busy2", 32'(busy2_o[0]), 32'h1);
    check("iss_cnt", 32'(cnt_o[0]), 32'h1);
    commit();
    drive(1'b0, 1'b1, 4'd5, 16'h00A5, 1'b0, 4'd0, 4'd0, 4'd5);
    commit();
    idle_read(4'd0, 4'd5);
    check("wb_busy2", 32'(busy2_o[0]), 32'h0);
    check("wb_rd2", 32'(rd2_o[0]), 32'h00A5);
    check("wb_cnt", 32'(cnt_o[0]), 32'h0);
    commit();

    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 4'd7, 4'd7);
    commit();
    drive(1'b0, 1'b1, 4'd7, 16'h7777, 1'b1, 4'd7, 4'd7, 4'd7);
    check("sup_byp_busy", 32'(busy1_o[0]), 32'h1);
    commit();
    idle_read(4'd7, 4'd7);
    check("sup_rd1", 32'(rd1_o[0]), 32'h7777);
    check("sup_busy1", 32'(busy1_o[0]), 32'h1);
    check("sup_cnt", 32'(cnt_o[0]), 32'h1);
    commit();

    for (int a = 1; a <= 4; a++) begin
      drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(a), 4'(a), 4'd0);
      commit();
    end
    drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    commit();
    drive(1'b0, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd0, 4'd2, 4'd2);
    commit();
    idle_read(4'd2, 4'd2);
    check("mrst_rd1", 32'(rd1_o[0]), 32'h2222);
    check("mrst_cnt", 32'(cnt_o[0]), 32'h0);
    commit();
    for (int a = 0; a < 16; a++) begin
      idle_read(4'(a), 4'(a));
      check("mrst_busy", 32'(busy1_o[0]), 32'h0);
      commit();
    end

    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom), 16'($urandom),
            1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      commit();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
